// File: rtl/watch_ctrl_if.sv
// Bundle between the keypad/button front-end, the counter datapaths and the
// watch controller. The controller side uses the slave modport.
interface watch_ctrl_if;
    // Handshake: key_valid is a one-cycle strobe qualifying key_code and has no
    // ready; the controller samples every strobe. set_load, sw_clear and
    // entry_err are one-cycle strobes the receivers must take when high.
    logic        mode_btn;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [23:0] cur_time;

    logic [1:0]  mode;
    logic        setting;
    logic [2:0]  edit_pos;
    logic [23:0] set_time;
    logic        set_load;
    logic        run_en;
    logic        sw_run;
    logic        sw_clear;
    logic [5:0]  digit_blank;
    logic        entry_err;
    logic [1:0]  state_dbg;

    modport master (
        output mode_btn, key_code, key_valid, cur_time,
        input  mode, setting, edit_pos, set_time, set_load, run_en,
               sw_run, sw_clear, digit_blank, entry_err, state_dbg
    );

    modport slave (
        input  mode_btn, key_code, key_valid, cur_time,
        output mode, setting, edit_pos, set_time, set_load, run_en,
               sw_run, sw_clear, digit_blank, entry_err, state_dbg
    );
endinterface

// File: rtl/watch_ctrl.sv
// Watch controller: mode FSM, keypad decode, digit-by-digit time entry with
// range checks, entry timeout and edit-digit blink.
module watch_ctrl #(
    parameter int CLK_HZ    = 1000,
    parameter int TIMEOUT_S = 10,
    parameter int BLINK_MS  = 250
) (
    input  logic       clk,
    input  logic       rst,
    watch_ctrl_if.slave bus
);
    localparam int TO_MAX    = TIMEOUT_S * CLK_HZ - 1;
    localparam int BLINK_CYC = BLINK_MS * CLK_HZ / 1000;
    localparam int TO_W      = $clog2(TO_MAX + 1);
    localparam int BL_W      = $clog2(BLINK_CYC + 1);
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        ST_CLOCK     = 2'd0,
        ST_ENTRY     = 2'd1,
        ST_CONFIRM   = 2'd2,
        ST_STOPWATCH = 2'd3
    } state_t;

    state_t          state;
    logic            btn_q;
    logic [TO_W-1:0] to_cnt;
    logic [BL_W-1:0] blink_cnt;
    logic            blink_on;

    logic        in_set;
    logic        btn_rise;
    logic        abort;
    logic [3:0]  digit_max;
    logic        digit_ok;
    logic [4:0]  nib_lsb;
    logic [23:0] written;
    logic [5:0]  pos_mask;

    assign bus.state_dbg = state;
    assign in_set   = (state == ST_ENTRY) || (state == ST_CONFIRM);
    assign btn_rise = bus.mode_btn & ~btn_q;
    // A mode edge always wins; the timeout only fires on a cycle with no key.
    assign abort    = in_set && (btn_rise ||
                      (!bus.key_valid && to_cnt == TO_W'(TO_MAX)));
    assign nib_lsb  = 5'd20 - {bus.edit_pos, 2'b00};
    assign pos_mask = 6'b100000 >> bus.edit_pos;

    always_comb begin
        digit_max = 4'd9;
        case (bus.edit_pos)
            3'd0:       digit_max = 4'd2;
            3'd1:       digit_max = (bus.set_time[23:20] < 4'd2) ? 4'd9 : 4'd3;
            3'd2, 3'd4: digit_max = 4'd5;
            default:    digit_max = 4'd9;
        endcase
        digit_ok = (bus.key_code <= 4'd9) && (bus.key_code <= digit_max);
    end

    // Buffer with the digit under edit replaced; an h_ten of 2 clamps h_one.
    always_comb begin
        written = (bus.set_time & ~(24'hF << nib_lsb)) |
                  ({20'd0, bus.key_code} << nib_lsb);
        if (bus.edit_pos == 3'd0 && bus.key_code == 4'd2 &&
            bus.set_time[19:16] > 4'd3)
            written[19:16] = 4'd3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_CLOCK;
            btn_q           <= 1'b0;
            to_cnt          <= '0;
            blink_cnt       <= '0;
            blink_on        <= 1'b0;
            bus.mode        <= 2'b00;
            bus.setting     <= 1'b0;
            bus.edit_pos    <= 3'd0;
            bus.set_time    <= 24'd0;
            bus.set_load    <= 1'b0;
            bus.run_en      <= 1'b1;
            bus.sw_run      <= 1'b0;
            bus.sw_clear    <= 1'b0;
            bus.digit_blank <= 6'd0;
            bus.entry_err   <= 1'b0;
        end else begin
            btn_q         <= bus.mode_btn;
            bus.set_load  <= 1'b0;
            bus.sw_clear  <= 1'b0;
            bus.entry_err <= 1'b0;

            if (abort) begin
                state           <= ST_CLOCK;
                bus.mode        <= 2'b00;
                bus.setting     <= 1'b0;
                bus.run_en      <= 1'b1;
                bus.digit_blank <= 6'd0;
                to_cnt          <= '0;
                blink_cnt       <= '0;
                blink_on        <= 1'b0;
            end else if (btn_rise) begin
                if (state == ST_CLOCK) begin
                    state    <= ST_STOPWATCH;
                    bus.mode <= 2'b01;
                end else begin
                    state    <= ST_CLOCK;
                    bus.mode <= 2'b00;
                end
            end else if (bus.key_valid) begin
                to_cnt          <= '0;
                blink_cnt       <= '0;
                blink_on        <= 1'b0;
                bus.digit_blank <= 6'd0;
                case (state)
                    ST_CLOCK: begin
                        if (bus.key_code == KEY_STAR) begin
                            state        <= ST_ENTRY;
                            bus.setting  <= 1'b1;
                            bus.set_time <= bus.cur_time;
                            bus.edit_pos <= 3'd0;
                            bus.run_en   <= 1'b0;
                        end
                    end
                    ST_ENTRY: begin
                        if (bus.key_code <= 4'd9) begin
                            if (digit_ok) begin
                                bus.set_time <= written;
                                if (bus.edit_pos < 3'd5)
                                    bus.edit_pos <= bus.edit_pos + 3'd1;
                                else
                                    state <= ST_CONFIRM;
                            end else begin
                                bus.entry_err <= 1'b1;
                            end
                        end else if (bus.key_code == KEY_STAR) begin
                            if (bus.edit_pos != 3'd0)
                                bus.edit_pos <= bus.edit_pos - 3'd1;
                        end
                    end
                    ST_CONFIRM: begin
                        if (bus.key_code == KEY_HASH) begin
                            state        <= ST_CLOCK;
                            bus.setting  <= 1'b0;
                            bus.set_load <= 1'b1;
                            bus.run_en   <= 1'b1;
                        end else if (bus.key_code == KEY_STAR) begin
                            state        <= ST_ENTRY;
                            bus.edit_pos <= 3'd5;
                        end
                    end
                    ST_STOPWATCH: begin
                        if (bus.key_code == KEY_STAR) begin
                            bus.sw_run <= ~bus.sw_run;
                        end else if (bus.key_code == KEY_HASH) begin
                            bus.sw_clear <= 1'b1;
                            bus.sw_run   <= 1'b0;
                        end
                    end
                    default: state <= ST_CLOCK;
                endcase
            end else if (in_set) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (blink_cnt == BL_W'(BLINK_CYC - 1)) begin
                    blink_cnt       <= '0;
                    blink_on        <= ~blink_on;
                    bus.digit_blank <= blink_on ? 6'd0 : pos_mask;
                end else begin
                    blink_cnt <= blink_cnt + BL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_watch_ctrl.sv
// Bench for watch_ctrl: directed sequences plus random key/button traffic,
// checked against a digit-array reference model through an expected queue.
module tb_watch_ctrl;
    typedef struct packed {
        logic [1:0]  mode;
        logic        setting;
        logic [2:0]  edit_pos;
        logic [23:0] set_time;
        logic        set_load;
        logic        run_en;
        logic        sw_run;
        logic        sw_clear;
        logic [5:0]  digit_blank;
        logic        entry_err;
    } snap_t;
    localparam int W = $bits(snap_t);
    localparam int BLINK = 250;
    localparam int TOUT  = 10000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic probe = 1'b0;
    watch_ctrl_if bus_if ();

    watch_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 clock, 1 entry, 2 confirm, 3 stopwatch.
    int m_st, m_pos, since, exp_loads, seen_loads;
    int m_dig[6];
    bit m_run_en, m_sw_run;

    task automatic model_reset();
        m_st = 0; m_pos = 0; since = 0; m_run_en = 1; m_sw_run = 0;
        for (int i = 0; i < 6; i++) m_dig[i] = 0;
    endtask

    task automatic model_btn();
        if (m_st == 0) m_st = 3;
        else if (m_st == 3) m_st = 0;
        else begin m_st = 0; m_run_en = 1; end
    endtask

    task automatic model_key(input int k, input logic [23:0] cur,
                             output bit ld, output bit clr, output bit err);
        int lim;
        ld = 0; clr = 0; err = 0;
        case (m_st)
            0: if (k == 14) begin
                for (int i = 0; i < 6; i++) m_dig[i] = int'((cur >> (20 - 4 * i)) & 24'hF);
                m_pos = 0; m_run_en = 0; m_st = 1;
            end
            1: if (k <= 9) begin
                case (m_pos)
                    0: lim = 2;
                    1: lim = (m_dig[0] < 2) ? 9 : 3;
                    2, 4: lim = 5;
                    default: lim = 9;
                endcase
                if (k <= lim) begin
                    m_dig[m_pos] = k;
                    if (m_pos == 0 && k == 2 && m_dig[1] > 3) m_dig[1] = 3;
                    if (m_pos < 5) m_pos++; else m_st = 2;
                end else err = 1;
            end else if (k == 14 && m_pos > 0) m_pos--;
            2: if (k == 15) begin
                ld = 1; m_st = 0; m_run_en = 1; exp_loads++;
            end else if (k == 14) begin
                m_st = 1; m_pos = 5;
            end
            default: if (k == 14) m_sw_run = !m_sw_run;
                     else if (k == 15) begin clr = 1; m_sw_run = 0; end
        endcase
    endtask

    task automatic advance(input int j);
        since += j;
        if ((m_st == 1 || m_st == 2) && since >= TOUT) begin m_st = 0; m_run_en = 1; end
    endtask

    task automatic push(input bit ld, input bit clr, input bit err, input string nm);
        snap_t s;
        logic [23:0] t;
        t = 24'd0;
        for (int i = 0; i < 6; i++) t = {t[19:0], 4'(m_dig[i])};
        s.mode        = (m_st == 3) ? 2'b01 : 2'b00;
        s.setting     = (m_st == 1 || m_st == 2);
        s.edit_pos    = 3'(m_pos);
        s.set_time    = t;
        s.set_load    = ld;
        s.run_en      = m_run_en;
        s.sw_run      = m_sw_run;
        s.sw_clear    = clr;
        s.entry_err   = err;
        s.digit_blank = (s.setting && ((since / BLINK) % 2 == 1)) ? (6'b100000 >> m_pos) : 6'd0;
        exp_q.push_back(W'(s));
        name_q.push_back(nm);
    endtask

    // Driver tasks: each is entered and left just after a falling edge.
    task automatic do_key(input logic [3:0] k, input string nm);
        bit ld, clr, err;
        model_key(int'(k), bus_if.cur_time, ld, clr, err);
        since = 0;
        push(ld, clr, err, nm);
        bus_if.key_code = k; bus_if.key_valid = 1'b1;
        @(negedge clk); bus_if.key_valid = 1'b0;
        @(negedge clk); advance(1);
    endtask

    task automatic do_btn(input string nm);
        model_btn();
        push(0, 0, 0, nm);
        bus_if.mode_btn = 1'b1;
        @(negedge clk); bus_if.mode_btn = 1'b0;
        @(negedge clk); advance(2);
    endtask

    task automatic do_btn_key(input logic [3:0] k, input string nm);
        model_btn();
        push(0, 0, 0, nm);
        bus_if.mode_btn = 1'b1; bus_if.key_code = k; bus_if.key_valid = 1'b1;
        @(negedge clk); bus_if.mode_btn = 1'b0; bus_if.key_valid = 1'b0;
        @(negedge clk); advance(2);
    endtask

    task automatic do_probe(input string nm);
        advance(1);
        push(0, 0, 0, nm);
        probe = 1'b1;
        @(negedge clk); probe = 1'b0;
    endtask

    task automatic do_idle(input int j);
        repeat (j) @(negedge clk);
        advance(j);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [23:0] rand_time();
        logic [3:0] ht, ho;
        ht = 4'($urandom_range(0, 2));
        ho = 4'($urandom_range(0, (ht == 4'd2) ? 3 : 9));
        return {ht, ho, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    // Monitor: the DUT presents a response on the falling edge after any
    // sampled key strobe, mode-button rise or probe.
    initial begin : monitor
        snap_t act, e;
        string nm;
        logic ev, btn_prev, pulse_prev;
        btn_prev = 1'b0; pulse_prev = 1'b0;
        forever begin
            @(posedge clk);
            ev = bus_if.key_valid | (bus_if.mode_btn & ~btn_prev) | probe;
            btn_prev = bus_if.mode_btn;
            @(negedge clk);
            act.mode = bus_if.mode;           act.setting = bus_if.setting;
            act.edit_pos = bus_if.edit_pos;   act.set_time = bus_if.set_time;
            act.set_load = bus_if.set_load;   act.run_en = bus_if.run_en;
            act.sw_run = bus_if.sw_run;       act.sw_clear = bus_if.sw_clear;
            act.digit_blank = bus_if.digit_blank; act.entry_err = bus_if.entry_err;
            if (act.set_load) seen_loads++;
            if (ev && rst) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL no_expectation: got %h with empty queue", act);
                end else begin
                    e = snap_t'(exp_q.pop_front());
                    nm = name_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL %s: got mode=%b set=%b pos=%0d time=%h ld=%b run=%b sw=%b clr=%b blank=%b err=%b, exp mode=%b set=%b pos=%0d time=%h ld=%b run=%b sw=%b clr=%b blank=%b err=%b",
                                 nm, act.mode, act.setting, act.edit_pos, act.set_time, act.set_load,
                                 act.run_en, act.sw_run, act.sw_clear, act.digit_blank, act.entry_err,
                                 e.mode, e.setting, e.edit_pos, e.set_time, e.set_load,
                                 e.run_en, e.sw_run, e.sw_clear, e.digit_blank, e.entry_err);
                    end
                end
            end else if (pulse_prev) begin
                n_tests++;
                if (act.set_load || act.sw_clear || act.entry_err) begin
                    n_fail++;
                    $display("FAIL pulse_width: got ld=%b clr=%b err=%b, exp all 0",
                             act.set_load, act.sw_clear, act.entry_err);
                end
            end
            pulse_prev = act.set_load | act.sw_clear | act.entry_err;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r;
        logic [3:0] k;
        bus_if.mode_btn = 1'b0; bus_if.key_valid = 1'b0;
        bus_if.key_code = 4'd0; bus_if.cur_time = 24'd0;
        exp_loads = 0; seen_loads = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_probe("reset_state");

        // Enter set mode and observe blink phase.
        bus_if.cur_time = 24'h123456;
        do_key(4'hE, "enter_set");
        do_idle(238);
        do_probe("blink_off_240");
        do_idle(19);
        do_probe("blink_on_260");
        do_btn("abort_by_btn");

        // Full entry and confirm.
        do_key(4'hE, "enter_set2");
        do_key(4'd2, "dig_h_ten");  do_key(4'd3, "dig_h_one");
        do_key(4'd5, "dig_m_ten");  do_key(4'd9, "dig_m_one");
        do_key(4'd5, "dig_s_ten");  do_key(4'd8, "dig_s_one");
        do_key(4'hF, "confirm_load");

        // Digit limits, h_one clamp, then timeout.
        bus_if.cur_time = 24'h070000;
        do_key(4'hE, "enter_set3");
        do_key(4'd3, "reject_pos0");
        do_key(4'd2, "clamp_h_one");
        do_key(4'd3, "pos1_limit3");
        do_key(4'd6, "reject_pos2");
        do_idle(9988);
        do_probe("before_timeout");
        do_idle(19);
        do_probe("after_timeout");

        // Stopwatch controls.
        do_btn("to_stopwatch");
        do_key(4'hE, "sw_start");
        do_key(4'hE, "sw_stop");
        do_key(4'hE, "sw_start2");
        do_key(4'hF, "sw_clear");
        do_btn("to_clock");

        // Mode edge beats a simultaneous key.
        do_btn_key(4'hE, "btn_beats_key");
        do_btn("back_to_clock");

        // Back-step, confirm back-out, then reset mid-entry.
        do_key(4'hE, "enter_set4");
        do_key(4'hE, "star_sat_pos0");
        do_key(4'd1, "dig_pos0");
        do_key(4'hE, "star_back");
        do_key(4'hF, "hash_ignored");
        do_reset();
        do_probe("reset_mid_entry");

        for (int i = 0; i < 400; i++) begin
            bus_if.cur_time = rand_time();
            r = $urandom_range(0, 19);
            if (r < 10) k = 4'(r);
            else if (r < 13) k = 4'hE;
            else if (r < 16) k = 4'hF;
            else k = 4'($urandom_range(10, 13));
            if (r == 17 || r == 18) do_btn("rand_btn");
            else if (r == 19) do_btn_key(k, "rand_btn_key");
            else do_key(k, "rand_key");
            do_idle($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, exp 0", exp_q.size());
        end
        n_tests++;
        if (seen_loads != exp_loads) begin
            n_fail++;
            $display("FAIL load_count: got %0d set_load pulses, exp %0d", seen_loads, exp_loads);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
